// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first, repeat_cnt times, with gap_len
// idle cycles between repetitions. Start/busy/done handshake plus synchronous abort.
module seq_pattern_tx #(
   parameter int unsigned             PAT_W   = 4,
   parameter logic [PAT_W-1:0]        PATTERN = 4'b1011,
   parameter int unsigned             CNT_W   = 8,
   parameter int unsigned             GAP_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap_len,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
   logic [CNT_W-1:0] rep_left, rep_left_nxt;
   logic [GAP_W-1:0] gap_left, gap_left_nxt;
   logic [GAP_W-1:0] gap_q, gap_q_nxt;
   logic             dout_nxt, dout_valid_nxt, busy_nxt, done_nxt;
   logic             accept_c;

   assign accept_c = start && (repeat_cnt != '0);

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         bit_idx    <= '0;
         rep_left   <= '0;
         gap_left   <= '0;
         gap_q      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_idx    <= bit_idx_nxt;
         rep_left   <= rep_left_nxt;
         gap_left   <= gap_left_nxt;
         gap_q      <= gap_q_nxt;
         dout       <= dout_nxt;
         dout_valid <= dout_valid_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   // Next state; rep_left holds repetitions still owed including the one on the wire
   always_comb begin
      state_nxt      = state;
      bit_idx_nxt    = bit_idx;
      rep_left_nxt   = rep_left;
      gap_left_nxt   = gap_left;
      gap_q_nxt      = gap_q;
      dout_nxt       = 1'b0;
      dout_valid_nxt = 1'b0;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (accept_c) begin
               state_nxt      = SHIFT;
               bit_idx_nxt    = LAST_IDX;
               rep_left_nxt   = repeat_cnt;
               gap_q_nxt      = gap_len;
               dout_nxt       = PATTERN[PAT_W-1];
               dout_valid_nxt = 1'b1;
               busy_nxt       = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end

         SHIFT: begin
            if (abort) begin
               state_nxt    = IDLE;
               rep_left_nxt = '0;
               gap_left_nxt = '0;
            end else if (bit_idx != '0) begin
               bit_idx_nxt    = bit_idx - IDX_W'(1);
               dout_nxt       = PATTERN[bit_idx_nxt];
               dout_valid_nxt = 1'b1;
               busy_nxt       = 1'b1;
            end else if (rep_left > CNT_W'(1)) begin
               rep_left_nxt = rep_left - CNT_W'(1);
               busy_nxt     = 1'b1;
               if (gap_q == '0) begin
                  bit_idx_nxt    = LAST_IDX;
                  dout_nxt       = PATTERN[PAT_W-1];
                  dout_valid_nxt = 1'b1;
               end else begin
                  state_nxt    = GAP;
                  gap_left_nxt = gap_q;
               end
            end else begin
               state_nxt    = DONE;
               rep_left_nxt = '0;
               done_nxt     = 1'b1;
            end
         end

         GAP: begin
            if (abort) begin
               state_nxt    = IDLE;
               rep_left_nxt = '0;
               gap_left_nxt = '0;
            end else if (gap_left == GAP_W'(1)) begin
               state_nxt      = SHIFT;
               gap_left_nxt   = '0;
               bit_idx_nxt    = LAST_IDX;
               dout_nxt       = PATTERN[PAT_W-1];
               dout_valid_nxt = 1'b1;
               busy_nxt       = 1'b1;
            end else begin
               gap_left_nxt = gap_left - GAP_W'(1);
               busy_nxt     = 1'b1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter that drives a 1-bit stream carrying a fixed bit pattern (default 1011) MSB first. It is the source end of the serial pattern link: it feeds pattern-detector blocks in-system and in loopback benches. A start request sends the pattern a programmable number of times, with an optional programmable idle gap between repetitions. A start/busy/done handshake is provided, plus an abort input.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
PATTERN, 4'b1011, pattern to transmit; bit PAT_W-1 is sent first
CNT_W, 8, width of the repetition counter
GAP_W, 4, width of the inter-repetition gap length

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request to begin a transmission; sampled only when busy=0
repeat_cnt  input  CNT_W  number of pattern repetitions; captured on accepted start
gap_len  input  GAP_W  idle cycles between repetitions; captured on accepted start
abort  input  1  synchronous cancel of an active transmission
dout  output  1  serial data bit
dout_valid  output  1  dout carries a pattern bit this cycle
busy  output  1  transmission in progress
done  output  1  one-cycle pulse after the last bit of a completed transmission

Behaviour:
- All outputs are registered.
- Reset (reset=0), asynchronous and any time including mid-transmission:
  - dout=0, dout_valid=0, busy=0, done=0, state=IDLE, counters cleared.
  - Release takes effect at the next rising edge.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE / DONE (busy=0):
  - start=1 with repeat_cnt!=0 is accepted at edge N. repeat_cnt and gap_len are latched.
  - From edge N: state=SHIFT, busy=1, dout_valid=1, dout=PATTERN[PAT_W-1]. Latency from start sampled to first bit is 1 edge.
  - start=1 with repeat_cnt==0 is ignored: no bits, no done.
  - DONE lasts exactly 1 cycle (done=1), then IDLE unless a new start is accepted in that cycle, which goes straight to SHIFT.
- SHIFT:
  - Each edge advances one bit: PATTERN[PAT_W-1] down to PATTERN[0].
  - After the LSB, if repetitions remain:
    - gap_len==0: the next edge emits the MSB again (back-to-back).
    - gap_len>0: enter GAP.
  - After the LSB of the final repetition, the next edge sets state=DONE, busy=0, dout_valid=0, dout=0, done=1.
- GAP:
  - Lasts exactly gap_len cycles with dout=0, dout_valid=0, busy=1.
  - Then SHIFT with the MSB.
  - No gap after the final repetition.
- Totals for R=repeat_cnt, G=gap_len:
  - Valid bits = R*PAT_W.
  - Busy cycles = R*PAT_W + (R-1)*G.
- start while busy=1: ignored, with no effect on the latched repeat_cnt or gap_len.
- abort=1 while busy=1:
  - Next edge: IDLE, busy=0, dout_valid=0, dout=0, done stays 0.
  - abort has priority over bit advance.
  - abort while idle has no effect.
  - abort and start together while idle: start wins.
- Repetition counter counts down from R. Full CNT_W range is supported; R=2^CNT_W-1 must not wrap.
- dout=0 whenever dout_valid=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> all outputs 0. Assert reset=0 mid-SHIFT -> outputs 0 immediately (before the next edge), IDLE after release.
- Single send, R=1, G=0: start at edge N -> dout 1,0,1,1 at edges N..N+3 with dout_valid=1 and busy=1. Edge N+4: done=1, busy=0. Edge N+5: done=0.
- Back-to-back, R=3, G=0 -> 12 valid bits 101110111011, no valid gaps. A loopback checker counting 1011 occurrences reports 3. done pulses once.
- Gapped, R=2, G=3 -> 1011, then 3 cycles dout_valid=0/dout=0, then 1011. Busy for 11 cycles.
- Handshake edges:
  - start pulsed while busy -> ignored; bit count is unchanged.
  - start in the done cycle -> MSB on the next edge, no IDLE cycle.
  - repeat_cnt=0 -> no activity, done stays 0.
- Abort: R=4, abort during the 2nd repetition at bit 2 -> next edge busy=0, dout_valid=0, done never pulses. A following start works normally.
